// File: rtl/launchpad_pkg.sv
// Shared types and helpers for the launchpad input conditioning path.
// Holds the button FSM state encoding and counter width.
package launchpad_pkg;

  localparam int BTN_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    HOLD   = 3'd2,
    FOLLOW = 3'd3,
    REL    = 3'd4
  } btn_state_t;

  function automatic logic [BTN_CNT_W-1:0] sat_inc(
    input logic [BTN_CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pad inputs.
// Resets both stages to 0 alongside the consuming logic.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_s1;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_s1   <= d;
      r_sync <= r_s1;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/button_conditioner.sv
// Debounces a pad button and stretches each accepted press
// to a minimum high time for the event generator.
module button_conditioner
  import launchpad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_HOLD        = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic button_raw,
  output logic button_out,
  output logic press_pulse,
  output logic busy
);

  localparam logic [BTN_CNT_W-1:0] DEB_LAST =
    BTN_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BTN_CNT_W-1:0] HOLD_LAST =
    BTN_CNT_W'(MIN_HOLD);
  localparam bit DEB_ONE = (DEBOUNCE_CYCLES == 1);

  logic                 w_sync;
  btn_state_t           r_state;
  btn_state_t           w_nxt;
  logic [BTN_CNT_W-1:0] r_deb;
  logic [BTN_CNT_W-1:0] w_deb_nxt;
  logic [BTN_CNT_W-1:0] r_hold;
  logic [BTN_CNT_W-1:0] w_hold_nxt;
  logic                 r_out;
  logic                 r_pulse;
  logic                 r_busy;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (button_raw),
    .q   (w_sync)
  );

  always_comb begin
    w_nxt      = r_state;
    w_deb_nxt  = r_deb;
    w_hold_nxt = r_hold;
    unique case (r_state)
      IDLE: begin
        w_deb_nxt  = '0;
        w_hold_nxt = '0;
        if (w_sync) begin
          if (DEB_ONE) begin
            w_nxt      = HOLD;
            w_hold_nxt = BTN_CNT_W'(1);
          end else begin
            w_nxt     = ARM;
            w_deb_nxt = BTN_CNT_W'(1);
          end
        end
      end
      ARM: begin
        if (!w_sync) begin
          w_nxt     = IDLE;
          w_deb_nxt = '0;
        end else if (r_deb == DEB_LAST) begin
          w_nxt      = HOLD;
          w_deb_nxt  = '0;
          w_hold_nxt = BTN_CNT_W'(1);
        end else begin
          w_deb_nxt = sat_inc(r_deb);
        end
      end
      // raw input is deliberately ignored until the hold expires
      HOLD: begin
        if (r_hold == HOLD_LAST) begin
          w_hold_nxt = '0;
          w_deb_nxt  = '0;
          w_nxt      = w_sync ? FOLLOW : REL;
        end else begin
          w_hold_nxt = sat_inc(r_hold);
        end
      end
      FOLLOW: begin
        w_deb_nxt = '0;
        if (!w_sync) begin
          if (DEB_ONE) begin
            w_nxt = IDLE;
          end else begin
            w_nxt     = REL;
            w_deb_nxt = BTN_CNT_W'(1);
          end
        end
      end
      REL: begin
        if (w_sync) begin
          w_nxt     = FOLLOW;
          w_deb_nxt = '0;
        end else if (r_deb == DEB_LAST) begin
          w_nxt     = IDLE;
          w_deb_nxt = '0;
        end else begin
          w_deb_nxt = sat_inc(r_deb);
        end
      end
      default: begin
        w_nxt      = IDLE;
        w_deb_nxt  = '0;
        w_hold_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_deb   <= '0;
      r_hold  <= '0;
      r_out   <= 1'b0;
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_deb   <= w_deb_nxt;
      r_hold  <= w_hold_nxt;
      r_out   <= (w_nxt == HOLD) || (w_nxt == FOLLOW) ||
                 (w_nxt == REL);
      r_pulse <= (w_nxt == HOLD) && (r_state != HOLD);
      r_busy  <= (w_nxt != IDLE);
    end
  end

  assign button_out  = r_out;
  assign press_pulse = r_pulse;
  assign busy        = r_busy;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: default and
// DEBOUNCE_CYCLES=1/MIN_HOLD=1 instances.
module tb_button_conditioner;

  localparam int D = 4;
  localparam int H = 9;

  typedef struct {
    bit sel;
    bit raw;
    bit rst;
    bit o;
    bit p;
    bit b;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic raw_a = 1'b0;
  logic raw_b = 1'b0;
  logic out_a, pls_a, bsy_a;
  logic out_b, pls_b, bsy_b;

  int n_run  = 0;
  int n_fail = 0;

  step_t stim_q[$];
  step_t sb_q[$];

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .MIN_HOLD(H)
  ) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .button_raw  (raw_a),
    .button_out  (out_a),
    .press_pulse (pls_a),
    .busy        (bsy_a)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(1),
    .MIN_HOLD(1)
  ) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .button_raw  (raw_b),
    .button_out  (out_b),
    .press_pulse (pls_b),
    .busy        (bsy_b)
  );

  task automatic check(input string tag, input logic obs,
                       input logic exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push(input bit sel, input bit r, input bit rs,
                      input bit o, input bit p, input bit b);
    step_t s;
    s.sel = sel; s.raw = r; s.rst = rs;
    s.o = o; s.p = p; s.b = b;
    stim_q.push_back(s);
  endtask

  // Drive each step, then compare after the edge.
  task automatic play(input string tag);
    step_t s;
    step_t e;
    int k;
    k = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      @(negedge clk);
      rst   = s.rst;
      raw_a = s.sel ? 1'b0 : s.raw;
      raw_b = s.sel ? s.raw : 1'b0;
      sb_q.push_back(s);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      if (e.sel) begin
        check($sformatf("%s out@%0d", tag, k), out_b, e.o);
        check($sformatf("%s pulse@%0d", tag, k), pls_b, e.p);
        check($sformatf("%s busy@%0d", tag, k), bsy_b, e.b);
      end else begin
        check($sformatf("%s out@%0d", tag, k), out_a, e.o);
        check($sformatf("%s pulse@%0d", tag, k), pls_a, e.p);
        check($sformatf("%s busy@%0d", tag, k), bsy_a, e.b);
      end
      k++;
    end
  endtask

  // Raw high on edges [a, a+len); expectations from timing rules.
  task automatic sc_press(input int len, input int total);
    int a, b, rise, fall;
    bit o, p, bz;
    a = 2;
    b = a + len;
    rise = a + D + 1;
    if (b <= a + D + H - 1) fall = a + 2 * D + H + 1;
    else fall = b + D + 1;
    for (int k = 0; k < total; k++) begin
      if (len < D) begin
        o = 0; p = 0;
        bz = (k >= a + 2) && (k < b + 2);
      end else begin
        o  = (k >= rise) && (k < fall);
        p  = (k == rise);
        bz = (k >= a + 2) && (k < fall);
      end
      push(0, (k >= a) && (k < b), 0, o, p, bz);
    end
  endtask

  task automatic sc_bounce();
    int a, b, fall;
    bit r;
    a = 2;
    b = a + 20;
    fall = b + 3 + D + 1;
    for (int k = 0; k < fall + 5; k++) begin
      r = ((k >= a) && (k < b)) || (k == b + 2);
      push(0, r, 0, (k >= a + D + 1) && (k < fall),
           k == a + D + 1, (k >= a + 2) && (k < fall));
    end
  endtask

  task automatic sc_reset();
    int a, r, b, fall;
    bit o, p, bz;
    a = 2;
    r = a + D + 4;
    b = r + 40;
    fall = b + D + 1;
    for (int k = 0; k < fall + 5; k++) begin
      if (k < r) begin
        o  = k >= a + D + 1;
        p  = k == a + D + 1;
        bz = k >= a + 2;
      end else begin
        o  = (k >= r + D + 2) && (k < fall);
        p  = k == r + D + 2;
        bz = (k >= r + 3) && (k < fall);
      end
      push(0, (k >= a) && (k < b), k == r, o, p, bz);
    end
  endtask

  task automatic sc_corner();
    push(1, 0, 1, 0, 0, 0);
    for (int k = 0; k < 10; k++)
      push(1, k == 2, 0, (k >= 4) && (k < 6), k == 4,
           (k >= 4) && (k < 6));
  endtask

  initial begin
    push(0, 0, 1, 0, 0, 0);
    push(0, 0, 1, 0, 0, 0);
    push(0, 0, 0, 0, 0, 0);
    play("reset");
    sc_press(2, 10);
    play("glitch2");
    sc_press(D - 1, 10);
    play("glitch3");
    sc_press(D, 26);
    play("minpress");
    sc_press(6, 26);
    play("tap");
    sc_press(30, 42);
    play("long");
    sc_bounce();
    play("bounce");
    sc_reset();
    play("rst_hold");
    sc_corner();
    play("corner");
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
